// File: rtl/arcsinus_if.sv
// arcsinus request/result bundle.
// Master drives operands and start; slave returns status and BCD angle.
interface arcsinus_if;
  logic       start;
  logic       sign_in;
  logic [3:0] hundreds_in;
  logic [3:0] tens_in;
  logic [3:0] ones_in;
  logic       busy;
  logic       done;
  logic       error;
  logic       sign;
  logic [3:0] hundreds;
  logic [3:0] tens;
  logic [3:0] ones;

  modport master (
    output start, sign_in, hundreds_in, tens_in, ones_in,
    input  busy, done, error, sign, hundreds, tens, ones
  );

  modport slave (
    input  start, sign_in, hundreds_in, tens_in, ones_in,
    output busy, done, error, sign, hundreds, tens, ones
  );
endinterface

// File: rtl/arcsinus.sv
// BCD arcsine: 7-step binary search over a 91-entry sine table.
// Returns signed whole degrees behind a start/busy/done handshake.
module arcsinus (
  input  logic clk,
  input  logic reset,
  arcsinus_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    CHECK,
    SEARCH,
    CONVERT
  } state_t;

  // round-half-up(100*sin(d deg)), d = 0..90
  localparam logic [6:0] TBL [0:90] = '{
    7'd0,   7'd2,   7'd3,   7'd5,   7'd7,
    7'd9,   7'd10,  7'd12,  7'd14,  7'd16,
    7'd17,  7'd19,  7'd21,  7'd22,  7'd24,
    7'd26,  7'd28,  7'd29,  7'd31,  7'd33,
    7'd34,  7'd36,  7'd37,  7'd39,  7'd41,
    7'd42,  7'd44,  7'd45,  7'd47,  7'd48,
    7'd50,  7'd52,  7'd53,  7'd54,  7'd56,
    7'd57,  7'd59,  7'd60,  7'd62,  7'd63,
    7'd64,  7'd66,  7'd67,  7'd68,  7'd69,
    7'd71,  7'd72,  7'd73,  7'd74,  7'd75,
    7'd77,  7'd78,  7'd79,  7'd80,  7'd81,
    7'd82,  7'd83,  7'd84,  7'd85,  7'd86,
    7'd87,  7'd87,  7'd88,  7'd89,  7'd90,
    7'd91,  7'd91,  7'd92,  7'd93,  7'd93,
    7'd94,  7'd95,  7'd95,  7'd96,  7'd96,
    7'd97,  7'd97,  7'd97,  7'd98,  7'd98,
    7'd98,  7'd99,  7'd99,  7'd99,  7'd99,
    7'd100, 7'd100, 7'd100, 7'd100, 7'd100,
    7'd100
  };

  state_t     state;
  logic       sgn;
  logic [3:0] hd;
  logic [3:0] td;
  logic [3:0] od;
  logic [6:0] m;
  logic [6:0] lo;
  logic [6:0] hi;
  logic [2:0] step;

  logic [9:0] m10;
  logic       ok;
  logic [6:0] mid;
  logic [6:0] dv;
  logic [3:0] tq;
  logic [3:0] oq;

  logic       busy_q;
  logic       done_q;
  logic       err_q;
  logic       sign_q;
  logic [3:0] hun_q;
  logic [3:0] ten_q;
  logic [3:0] one_q;

  always_comb begin
    m10 = 10'(hd) * 10'd100
        + 10'(td) * 10'd10
        + 10'(od);
    ok  = (hd <= 4'd9) && (td <= 4'd9)
       && (od <= 4'd9) && (m10 <= 10'd100);
    mid = lo + ((hi - lo) >> 1);
    dv  = (m == 7'd100) ? 7'd90 : lo;
    tq  = '0;
    for (int k = 1; k < 10; k++)
      if (dv >= 7'(k * 10)) tq = 4'(k);
    // remainder fits in a nibble, so mod-16 arithmetic is exact
    oq  = dv[3:0] - tq * 4'd10;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      sgn    <= 1'b0;
      hd     <= '0;
      td     <= '0;
      od     <= '0;
      m      <= '0;
      lo     <= '0;
      hi     <= '0;
      step   <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
      sign_q <= 1'b0;
      hun_q  <= '0;
      ten_q  <= '0;
      one_q  <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.start) begin
            sgn    <= bus.sign_in;
            hd     <= bus.hundreds_in;
            td     <= bus.tens_in;
            od     <= bus.ones_in;
            busy_q <= 1'b1;
            state  <= CHECK;
          end
        end
        CHECK: begin
          if (!ok) begin
            err_q  <= 1'b1;
            sign_q <= 1'b0;
            hun_q  <= '0;
            ten_q  <= '0;
            one_q  <= '0;
            done_q <= 1'b1;
            busy_q <= 1'b0;
            state  <= IDLE;
          end else begin
            m     <= m10[6:0];
            lo    <= '0;
            hi    <= 7'd90;
            step  <= '0;
            state <= SEARCH;
          end
        end
        SEARCH: begin
          if (lo < hi) begin
            if (TBL[mid] >= m) hi <= mid;
            else               lo <= mid + 7'd1;
          end
          step <= step + 3'd1;
          if (step == 3'd6) state <= CONVERT;
        end
        CONVERT: begin
          err_q  <= 1'b0;
          sign_q <= sgn && (dv != 7'd0);
          hun_q  <= '0;
          ten_q  <= tq;
          one_q  <= oq;
          done_q <= 1'b1;
          busy_q <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.error    = err_q;
  assign bus.sign     = sign_q;
  assign bus.hundreds = hun_q;
  assign bus.tens     = ten_q;
  assign bus.ones     = one_q;

endmodule

// File: tb/tb_arcsinus.sv
// Self-checking bench for arcsinus: vector table, hand sequences,
// and random requests against a real-arithmetic arcsine model.
module tb_arcsinus;

  logic clk = 1'b0;
  logic reset;
  arcsinus_if bus ();

  arcsinus dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int tbl [0:90];

  typedef struct {
    logic       s;
    logic [3:0] h;
    logic [3:0] t;
    logic [3:0] o;
    logic       e_err;
    logic       e_sg;
    logic [3:0] e_t;
    logic [3:0] e_o;
    int         e_lat;
  } vec_t;

  vec_t vecs [14];

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic model(
    input  logic s, input logic [3:0] h, t, o,
    output logic err, output logic sg,
    output logic [3:0] tn, output logic [3:0] on,
    output int lat
  );
    int mv;
    int d;
    mv = int'(h) * 100 + int'(t) * 10 + int'(o);
    if (h > 9 || t > 9 || o > 9 || mv > 100) begin
      err = 1'b1; sg = 1'b0; tn = '0; on = '0; lat = 1;
    end else begin
      d = 0;
      while (d < 90 && tbl[d] < mv) d++;
      if (mv == 100) d = 90;
      err = 1'b0;
      sg  = s && (d != 0);
      tn  = 4'(d / 10);
      on  = 4'(d % 10);
      lat = 9;
    end
  endtask

  task automatic run_req(
    input logic s, input logic [3:0] h, t, o,
    input logic e_err, input logic e_sg,
    input logic [3:0] e_t, input logic [3:0] e_o,
    input int e_lat, input string nm
  );
    int  cyc;
    bit  got;
    bit  busy_ok;
    bus.sign_in     = s;
    bus.hundreds_in = h;
    bus.tens_in     = t;
    bus.ones_in     = o;
    bus.start       = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    cyc = 0; got = 0; busy_ok = 1;
    while (!got && cyc < 20) begin
      if (bus.done) got = 1;
      else begin
        if (bus.busy !== 1'b1) busy_ok = 0;
        @(posedge clk); #1;
        cyc++;
      end
    end
    chk({nm, "_busy"}, int'(busy_ok), 1);
    if (!got) begin
      chk({nm, "_timeout"}, 0, 1);
    end else begin
      chk({nm, "_lat"}, cyc, e_lat);
      chk({nm, "_err"}, int'(bus.error), int'(e_err));
      chk({nm, "_sign"}, int'(bus.sign), int'(e_sg));
      chk({nm, "_hund"}, int'(bus.hundreds), 0);
      chk({nm, "_tens"}, int'(bus.tens), int'(e_t));
      chk({nm, "_ones"}, int'(bus.ones), int'(e_o));
      chk({nm, "_busy_done"}, int'(bus.busy), 0);
    end
    @(posedge clk); #1;
    chk({nm, "_done_drop"}, int'(bus.done), 0);
  endtask

  logic       os [80];
  logic [3:0] oh [80];
  logic [3:0] ot [80];
  logic [3:0] oo [80];
  int         done_src [80];

  initial begin
    logic       e_err;
    logic       e_sg;
    logic [3:0] e_t;
    logic [3:0] e_o;
    int         e_lat;
    int         na;
    bit         quiet;
    bit         held;

    for (int d = 0; d <= 90; d++)
      tbl[d] = int'($floor(100.0 * $sin(real'(d) * 3.14159265358979 / 180.0) + 0.5));

    vecs[0]  = '{1'b0, 4'd0, 4'd5, 4'd0, 1'b0, 1'b0, 4'd3, 4'd0, 9};
    vecs[1]  = '{1'b0, 4'd0, 4'd7, 4'd1, 1'b0, 1'b0, 4'd4, 4'd5, 9};
    vecs[2]  = '{1'b1, 4'd0, 4'd8, 4'd7, 1'b0, 1'b1, 4'd6, 4'd0, 9};
    vecs[3]  = '{1'b0, 4'd0, 4'd9, 4'd9, 1'b0, 1'b0, 4'd8, 4'd1, 9};
    vecs[4]  = '{1'b0, 4'd0, 4'd0, 4'd1, 1'b0, 1'b0, 4'd0, 4'd1, 9};
    vecs[5]  = '{1'b1, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 4'd0, 4'd0, 9};
    vecs[6]  = '{1'b0, 4'd1, 4'd0, 4'd0, 1'b0, 1'b0, 4'd9, 4'd0, 9};
    vecs[7]  = '{1'b0, 4'd1, 4'd0, 4'd1, 1'b1, 1'b0, 4'd0, 4'd0, 1};
    vecs[8]  = '{1'b1, 4'd0, 4'd10, 4'd0, 1'b1, 1'b0, 4'd0, 4'd0, 1};
    vecs[9]  = '{1'b0, 4'd0, 4'd4, 4'd8, 1'b0, 1'b0, 4'd2, 4'd9, 9};
    vecs[10] = '{1'b0, 4'd0, 4'd6, 4'd9, 1'b0, 1'b0, 4'd4, 4'd4, 9};
    vecs[11] = '{1'b0, 4'd0, 4'd9, 4'd8, 1'b0, 1'b0, 4'd7, 4'd8, 9};
    vecs[12] = '{1'b1, 4'd0, 4'd0, 4'd2, 1'b0, 1'b1, 4'd0, 4'd1, 9};
    vecs[13] = '{1'b0, 4'd0, 4'd8, 4'd6, 1'b0, 1'b0, 4'd5, 4'd9, 9};

    reset = 1'b1;
    bus.start = 1'b0;
    bus.sign_in = 1'b0;
    bus.hundreds_in = '0;
    bus.tens_in = '0;
    bus.ones_in = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_done", int'(bus.done), 0);
    chk("rst_err", int'(bus.error), 0);
    chk("rst_sign", int'(bus.sign), 0);
    chk("rst_digits", int'({bus.hundreds, bus.tens, bus.ones}), 0);
    reset = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 14; i++)
      run_req(vecs[i].s, vecs[i].h, vecs[i].t, vecs[i].o,
              vecs[i].e_err, vecs[i].e_sg, vecs[i].e_t, vecs[i].e_o,
              vecs[i].e_lat, $sformatf("vec%0d", i));

    for (int i = 0; i < 25; i++) begin
      logic       s;
      logic [3:0] h, t, o;
      s = 1'($urandom_range(0, 1));
      h = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(0, 15))
                                      : 4'($urandom_range(0, 1));
      t = 4'($urandom_range(0, ($urandom_range(0, 9) == 0) ? 15 : 9));
      o = 4'($urandom_range(0, 9));
      model(s, h, t, o, e_err, e_sg, e_t, e_o, e_lat);
      run_req(s, h, t, o, e_err, e_sg, e_t, e_o, e_lat,
              $sformatf("rnd%0d", i));
    end

    for (int c = 0; c < 80; c++) begin
      os[c] = 1'($urandom_range(0, 1));
      oh[c] = '0;
      ot[c] = 4'($urandom_range(0, 9));
      oo[c] = 4'($urandom_range(0, 9));
      if ($urandom_range(0, 7) == 0) oh[c] = 4'd1;
      done_src[c] = -1;
    end
    na = 0;
    while (na < 80) begin
      model(os[na], oh[na], ot[na], oo[na], e_err, e_sg, e_t, e_o, e_lat);
      if (na + e_lat < 80) done_src[na + e_lat] = na;
      na = na + e_lat + 1;
    end
    for (int c = 0; c < 80; c++) begin
      bus.sign_in     = os[c];
      bus.hundreds_in = oh[c];
      bus.tens_in     = ot[c];
      bus.ones_in     = oo[c];
      bus.start       = 1'b1;
      @(posedge clk); #1;
      if (done_src[c] >= 0) begin
        int a;
        a = done_src[c];
        model(os[a], oh[a], ot[a], oo[a], e_err, e_sg, e_t, e_o, e_lat);
        chk($sformatf("b2b%0d_done", c), int'(bus.done), 1);
        chk($sformatf("b2b%0d_res", c),
            int'({bus.error, bus.sign, bus.tens, bus.ones}),
            int'({e_err, e_sg, e_t, e_o}));
      end else begin
        chk($sformatf("b2b%0d_nodone", c), int'(bus.done), 0);
      end
    end
    bus.start = 1'b0;
    repeat (12) @(posedge clk);
    #1;

    run_req(1'b1, 4'd0, 4'd5, 4'd0, 1'b0, 1'b1, 4'd3, 4'd0, 9, "pre_rst");
    bus.sign_in = 1'b1;
    bus.hundreds_in = 4'd0;
    bus.tens_in = 4'd5;
    bus.ones_in = 4'd0;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    reset = 1'b1;
    bus.start = 1'b1;
    @(posedge clk); #1;
    chk("mid_rst_busy", int'(bus.busy), 0);
    chk("mid_rst_done", int'(bus.done), 0);
    chk("mid_rst_out",
        int'({bus.error, bus.sign, bus.hundreds, bus.tens, bus.ones}), 0);
    reset = 1'b0;
    bus.start = 1'b0;
    quiet = 1;
    repeat (12) begin
      @(posedge clk); #1;
      if (bus.done !== 1'b0 || bus.busy !== 1'b0) quiet = 0;
    end
    chk("mid_rst_quiet", int'(quiet), 1);
    run_req(1'b0, 4'd0, 4'd5, 4'd0, 1'b0, 1'b0, 4'd3, 4'd0, 9, "post_rst");

    run_req(1'b1, 4'd0, 4'd8, 4'd7, 1'b0, 1'b1, 4'd6, 4'd0, 9, "hold_a");
    bus.sign_in = 1'b0;
    bus.hundreds_in = 4'd0;
    bus.tens_in = 4'd5;
    bus.ones_in = 4'd0;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.tens_in = 4'd9;
    held = 1;
    for (int c = 0; c < 20 && !bus.done; c++) begin
      if ({bus.sign, bus.tens, bus.ones} !== {1'b1, 4'd6, 4'd0}) held = 0;
      @(posedge clk); #1;
    end
    chk("hold_during_busy", int'(held), 1);
    chk("hold_b_done", int'(bus.done), 1);
    chk("hold_b_res", int'({bus.sign, bus.tens, bus.ones}),
        int'({1'b0, 4'd3, 4'd0}));
    @(posedge clk); #1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
